gpio_rmw_arbiter: RTL and testbench

//  Shares one 8-bit output PIO slave (address/chipselect/write_n/writedata/readdata) among NUM_REQ

---
 rtl/gpio_rmw_arbiter_pkg.sv | 33 +++
 rtl/gpio_rmw_arbiter_rr_arbiter.sv | 31 +++
 rtl/gpio_rmw_arbiter.sv | 126 ++++++++++++
 tb/tb_gpio_rmw_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_rmw_arbiter_pkg.sv
// Shared definitions for the GPIO read-modify-write arbiter: op encodings,
// FSM states and the bit-mask update function.
package gpio_rmw_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int AVM_DATA_W = 32;

    // Operands are zero-extended by the caller, so upper bits stay zero for every op.
    function automatic logic [AVM_DATA_W-1:0] apply_op(input op_e op,
                                                       input logic [AVM_DATA_W-1:0] rd,
                                                       input logic [AVM_DATA_W-1:0] mask);
        case (op)
            OP_SET:    return rd | mask;
            OP_CLEAR:  return rd & ~mask;
            OP_TOGGLE: return rd ^ mask;
            default:   return mask;
        endcase
    endfunction

endpackage

// File: rtl/gpio_rmw_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the lowest requesting index at or above
// ptr wins, wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_rmw_arbiter.sv
// Shares one output PIO slave among NUM_REQ requesters; SET/CLEAR/TOGGLE are
// performed as an atomic read-modify-write, WRITE as a single write.
module gpio_rmw_arbiter
    import gpio_rmw_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int READ_WAIT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [2*NUM_REQ-1:0]  req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_mask,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy,
    output logic [DATA_W-1:0]     gpio_value,
    output logic [1:0]            avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(READ_WAIT + 1);

    state_e               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     rd_cnt;

    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_vld;

    op_e                  op_q;
    logic [DATA_W-1:0]    mask_q;
    logic [IDX_W-1:0]     win_idx_q;
    logic [NUM_REQ-1:0]   win_oh_q;

    logic [1:0]           sel_op;
    logic [DATA_W-1:0]    sel_mask;
    logic [31:0]          rmw_val;
    logic                 rd_unused;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign sel_op      = req_op[int'(grant_idx)*2 +: 2];
    assign sel_mask    = req_mask[int'(grant_idx)*DATA_W +: DATA_W];
    assign rmw_val     = apply_op(op_q, 32'(avm_readdata[DATA_W-1:0]), 32'(mask_q));
    assign rd_unused   = ^avm_readdata;
    assign busy        = (state != ST_IDLE);
    assign avm_address = 2'b00;

    // Operand latches are loaded on grant and only read while busy, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && grant_vld) begin
            op_q      <= op_e'(sel_op);
            mask_q    <= sel_mask;
            win_idx_q <= grant_idx;
            win_oh_q  <= grant;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            rd_cnt         <= '0;
            done           <= '0;
            gpio_value     <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        avm_chipselect <= 1'b1;
                        rd_cnt         <= '0;
                        if (op_e'(sel_op) == OP_WRITE) begin
                            avm_write_n   <= 1'b0;
                            avm_writedata <= 32'(sel_mask);
                            state         <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    // readdata is only trusted at the edge ending the last wait cycle
                    if (rd_cnt == CNT_W'(READ_WAIT - 1)) begin
                        avm_write_n   <= 1'b0;
                        avm_writedata <= rmw_val;
                        state         <= ST_WR;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                ST_WR: begin
                    avm_chipselect <= 1'b0;
                    avm_write_n    <= 1'b1;
                    gpio_value     <= avm_writedata[DATA_W-1:0];
                    done           <= win_oh_q;
                    state          <= ST_DONE;
                end
                ST_DONE: begin
                    done   <= '0;
                    rr_ptr <= (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_rmw_arbiter.sv
// Directed bench for gpio_rmw_arbiter: one instance with READ_WAIT=1 and one
// with READ_WAIT=3, each driving its own behavioural PIO model.
module tb_gpio_rmw_arbiter;
    import gpio_rmw_pkg::*;

    logic        clk;
    logic        reset_n;

    logic [3:0]  req_a;
    logic [7:0]  op_a;
    logic [31:0] mask_a;
    logic [3:0]  done_a;
    logic        busy_a;
    logic [7:0]  gpio_a;
    logic [1:0]  addr_a;
    logic        cs_a;
    logic        wn_a;
    logic [31:0] wd_a;
    logic [31:0] rdata_a;
    logic [7:0]  pio_a = 8'h00;

    logic [3:0]  req_b;
    logic [7:0]  op_b;
    logic [31:0] mask_b;
    logic [3:0]  done_b;
    logic        busy_b;
    logic [7:0]  gpio_b;
    logic [1:0]  addr_b;
    logic        cs_b;
    logic        wn_b;
    logic [31:0] wd_b;
    logic [31:0] rdata_b;
    logic [7:0]  pio_b = 8'h00;
    logic [7:0]  noise_b = 8'h00;

    int errors = 0;
    int checks = 0;

    gpio_rmw_arbiter #(.NUM_REQ(4), .DATA_W(8), .READ_WAIT(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .req(req_a), .req_op(op_a), .req_mask(mask_a),
        .done(done_a), .busy(busy_a), .gpio_value(gpio_a), .avm_address(addr_a),
        .avm_chipselect(cs_a), .avm_write_n(wn_a), .avm_writedata(wd_a),
        .avm_readdata(rdata_a)
    );

    gpio_rmw_arbiter #(.NUM_REQ(4), .DATA_W(8), .READ_WAIT(3)) u_dut_rw3 (
        .clk(clk), .reset_n(reset_n), .req(req_b), .req_op(op_b), .req_mask(mask_b),
        .done(done_b), .busy(busy_b), .gpio_value(gpio_b), .avm_address(addr_b),
        .avm_chipselect(cs_b), .avm_write_n(wn_b), .avm_writedata(wd_b),
        .avm_readdata(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO models; noise_b corrupts readdata during early wait cycles only.
    always @(posedge clk) if (cs_a && !wn_a && addr_a == 2'd0) pio_a <= wd_a[7:0];
    always @(posedge clk) if (cs_b && !wn_b && addr_b == 2'd0) pio_b <= wd_b[7:0];
    assign rdata_a = (addr_a == 2'd0) ? {24'h0, pio_a} : 32'h0;
    assign rdata_b = (addr_b == 2'd0) ? {24'h0, pio_b ^ noise_b} : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on instance A; observe latency, read cycles, write data and done vector.
    task automatic run_req(input int idx, input logic [1:0] op, input logic [7:0] mask,
                           output int lat, output int rd_cyc, output int wr_cyc,
                           output logic [31:0] wdata, output logic [3:0] done_vec);
        req_a[idx] = 1'b1;
        op_a[idx*2 +: 2] = op;
        mask_a[idx*8 +: 8] = mask;
        lat = -1; rd_cyc = 0; wr_cyc = 0; wdata = 32'h0; done_vec = 4'h0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if (cs_a && wn_a) rd_cyc++;
            if (cs_a && !wn_a) begin wr_cyc++; wdata = wd_a; end
            if (done_a[idx]) begin lat = k; done_vec = done_a; end
        end
        req_a[idx] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        checks++; if (cs_a !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", cs_a); end
        checks++; if (wn_a !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b want 1", wn_a); end
        checks++; if (done_a !== 4'h0) begin errors++; $display("FAIL reset_done: got %h want 0", done_a); end
        checks++; if (gpio_a !== 8'h00) begin errors++; $display("FAIL reset_gpio: got %h want 00", gpio_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if (wd_a !== 32'h0) begin errors++; $display("FAIL reset_writedata: got %h want 0", wd_a); end
        reset_n = 1'b1;
        tick(); tick();
        checks++; if ({cs_a, wn_a, busy_a, done_a} !== 7'b0100000) begin
            errors++; $display("FAIL post_reset_idle: got cs=%b wn=%b busy=%b done=%h want 0 1 0 0", cs_a, wn_a, busy_a, done_a);
        end
        checks++; if (addr_a !== 2'd0) begin errors++; $display("FAIL address: got %0d want 0", addr_a); end
    endtask

    task automatic test_write();
        int lat, rdc, wrc; logic [31:0] wd; logic [3:0] dv;
        run_req(0, OP_WRITE, 8'hA5, lat, rdc, wrc, wd, dv);
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d want 2", lat); end
        checks++; if (rdc !== 0) begin errors++; $display("FAIL write_rd_cycles: got %0d want 0", rdc); end
        checks++; if (wrc !== 1) begin errors++; $display("FAIL write_wr_cycles: got %0d want 1", wrc); end
        checks++; if (wd !== 32'h000000A5) begin errors++; $display("FAIL write_data: got %h want 000000a5", wd); end
        checks++; if (dv !== 4'b0001) begin errors++; $display("FAIL write_done_vec: got %b want 0001", dv); end
        checks++; if (pio_a !== 8'hA5) begin errors++; $display("FAIL write_pio: got %h want a5", pio_a); end
        checks++; if (gpio_a !== 8'hA5) begin errors++; $display("FAIL write_gpio: got %h want a5", gpio_a); end
        checks++; if (busy_a !== 1'b0 || done_a !== 4'h0) begin
            errors++; $display("FAIL write_return_idle: got busy=%b done=%h want 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_rmw();
        logic [1:0] ops [3] = '{OP_SET, OP_CLEAR, OP_TOGGLE};
        logic [7:0] msk [3] = '{8'h0F, 8'h03, 8'hFF};
        logic [7:0] exp [3] = '{8'hAF, 8'hAC, 8'h53};
        int lat, rdc, wrc; logic [31:0] wd; logic [3:0] dv;
        for (int i = 0; i < 3; i++) begin
            run_req(1, ops[i], msk[i], lat, rdc, wrc, wd, dv);
            checks++; if (lat !== 3) begin errors++; $display("FAIL rmw%0d_latency: got %0d want 3", i, lat); end
            checks++; if (rdc !== 1 || wrc !== 1) begin errors++; $display("FAIL rmw%0d_cycles: got rd=%0d wr=%0d want 1 1", i, rdc, wrc); end
            checks++; if (wd !== {24'h0, exp[i]}) begin errors++; $display("FAIL rmw%0d_data: got %h want %h", i, wd, exp[i]); end
            checks++; if (dv !== 4'b0010) begin errors++; $display("FAIL rmw%0d_done_vec: got %b want 0010", i, dv); end
            checks++; if (gpio_a !== exp[i] || pio_a !== exp[i]) begin
                errors++; $display("FAIL rmw%0d_value: got gpio=%h pio=%h want %h", i, gpio_a, pio_a, exp[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int lat, rdc, wrc; logic [31:0] wd; logic [3:0] dv;
        int order [$];
        int multi;
        int exp1 [4] = '{0, 1, 2, 3};
        // A WRITE 0 from requester 3 clears the PIO and returns the pointer to 0.
        run_req(3, OP_WRITE, 8'h00, lat, rdc, wrc, wd, dv);
        checks++; if (pio_a !== 8'h00) begin errors++; $display("FAIL rr_clear_pio: got %h want 00", pio_a); end
        op_a = {OP_SET, OP_SET, OP_SET, OP_SET};
        mask_a = {8'h40, 8'h10, 8'h04, 8'h01};
        req_a = 4'hF;
        multi = 0;
        for (int k = 0; k < 80 && order.size() < 4; k++) begin
            tick();
            if ($countones(done_a) > 1) multi++;
            for (int i = 0; i < 4; i++) if (done_a[i]) begin order.push_back(i); req_a[i] = 1'b0; end
        end
        req_a = 4'h0;
        tick();
        checks++; if (order.size() !== 4) begin errors++; $display("FAIL rr_count: got %0d want 4", order.size()); end
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            checks++; if (order[i] !== exp1[i]) begin errors++; $display("FAIL rr_order%0d: got %0d want %0d", i, order[i], exp1[i]); end
        end
        checks++; if (pio_a !== 8'h55) begin errors++; $display("FAIL rr_pio: got %h want 55", pio_a); end
        order.delete();
        mask_a = {8'h80, 8'h00, 8'h00, 8'h02};
        req_a = 4'b1001;
        for (int k = 0; k < 40 && order.size() < 2; k++) begin
            tick();
            if ($countones(done_a) > 1) multi++;
            for (int i = 0; i < 4; i++) if (done_a[i]) begin order.push_back(i); req_a[i] = 1'b0; end
        end
        req_a = 4'h0;
        tick();
        checks++; if (order.size() !== 2) begin errors++; $display("FAIL rr2_count: got %0d want 2", order.size()); end
        else begin
            checks++; if (order[0] !== 0 || order[1] !== 3) begin
                errors++; $display("FAIL rr2_order: got %0d,%0d want 0,3", order[0], order[1]);
            end
        end
        checks++; if (multi !== 0) begin errors++; $display("FAIL rr_multi_done: got %0d want 0", multi); end
        checks++; if (pio_a !== 8'hD7 || gpio_a !== 8'hD7) begin
            errors++; $display("FAIL rr2_pio: got pio=%h gpio=%h want d7", pio_a, gpio_a);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int lat, rdc, wrc; logic [31:0] wd; logic [3:0] dv;
        int stray;
        req_a[1] = 1'b1;
        op_a[3:2] = OP_SET;
        mask_a[15:8] = 8'h20;
        tick();
        checks++; if (cs_a !== 1'b1 || wn_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++; $display("FAIL mid_rd_state: got cs=%b wn=%b busy=%b want 1 1 1", cs_a, wn_a, busy_a);
        end
        reset_n = 1'b0;
        #1;
        checks++; if ({cs_a, wn_a, busy_a, done_a, gpio_a} !== {3'b010, 4'h0, 8'h00}) begin
            errors++; $display("FAIL mid_reset_outputs: got cs=%b wn=%b busy=%b done=%h gpio=%h want 0 1 0 0 00", cs_a, wn_a, busy_a, done_a, gpio_a);
        end
        stray = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (cs_a || done_a != 4'h0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL mid_reset_activity: got %0d want 0", stray); end
        checks++; if (pio_a !== 8'hD7) begin errors++; $display("FAIL mid_reset_pio: got %h want d7", pio_a); end
        reset_n = 1'b1;
        run_req(1, OP_SET, 8'h20, lat, rdc, wrc, wd, dv);
        checks++; if (lat !== 3) begin errors++; $display("FAIL refire_latency: got %0d want 3", lat); end
        checks++; if (wd !== 32'h000000F7) begin errors++; $display("FAIL refire_data: got %h want 000000f7", wd); end
        checks++; if (pio_a !== 8'hF7 || gpio_a !== 8'hF7) begin
            errors++; $display("FAIL refire_value: got pio=%h gpio=%h want f7", pio_a, gpio_a);
        end
    endtask

    task automatic test_read_wait3();
        logic [1:0] ops [2] = '{OP_SET, OP_TOGGLE};
        logic [7:0] msk [2] = '{8'h3C, 8'h0F};
        logic [7:0] exp [2] = '{8'h3C, 8'h33};
        for (int i = 0; i < 2; i++) begin
            int lat, rdc, wrc; logic [31:0] wd;
            req_b[2] = 1'b1;
            op_b[5:4] = ops[i];
            mask_b[23:16] = msk[i];
            lat = -1; rdc = 0; wrc = 0; wd = 32'h0;
            for (int k = 1; k <= 20 && lat < 0; k++) begin
                tick();
                if (cs_b && wn_b) begin rdc++; noise_b = (rdc < 3) ? 8'hFF : 8'h00; end
                else noise_b = 8'h00;
                if (cs_b && !wn_b) begin wrc++; wd = wd_b; end
                if (done_b[2]) lat = k;
            end
            noise_b = 8'h00;
            req_b[2] = 1'b0;
            tick();
            checks++; if (lat !== 5) begin errors++; $display("FAIL rw3_%0d_latency: got %0d want 5", i, lat); end
            checks++; if (rdc !== 3 || wrc !== 1) begin errors++; $display("FAIL rw3_%0d_cycles: got rd=%0d wr=%0d want 3 1", i, rdc, wrc); end
            checks++; if (wd !== {24'h0, exp[i]}) begin errors++; $display("FAIL rw3_%0d_data: got %h want %h", i, wd, exp[i]); end
            checks++; if (pio_b !== exp[i] || gpio_b !== exp[i]) begin
                errors++; $display("FAIL rw3_%0d_value: got pio=%h gpio=%h want %h", i, pio_b, gpio_b, exp[i]);
            end
        end
    endtask

    initial begin
        req_a = 4'h0; op_a = 8'h0; mask_a = 32'h0;
        req_b = 4'h0; op_b = 8'h0; mask_b = 32'h0;
        reset_n = 1'b0;
        test_reset();
        test_write();
        test_rmw();
        test_round_robin();
        test_reset_mid_rmw();
        test_read_wait3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
